buffer_drain: RTL and testbench
===============================

# buffer_drain

Credit-controlled drain for the delete-style read port of a flow buffer. Pops one item per cycle from the upstream buffer and re-emits it as a write strobe to a downstream block. Emission is limited by a credit counter that downstream replenishes, so downstream never sees more outstanding items than it can hold. It sits between a buffer's read side and the next stage's strobe-write input.

## Interface
- WIDTH, 32, data width in bits.
- CREDITS, 64, initial and maximum credit count; equals downstream capacity in items; must be ≥1.
- LOG_CREDITS, 6, width such that CREDITS ≤ 2^LOG_CREDITS; the counter is LOG_CREDITS+1 bits.
- clk  in  1  single clock; everything is on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- enable  in  1  drain permitted when 1; when 0, no new pops start.
- in_full  in  1  upstream head item valid.
- in_data  in  WIDTH  upstream head item.
- in_delete  out  1  registered; pops the upstream head.
- out_strobe  out  1  registered; out_data valid this cycle.
- out_data  out  WIDTH  registered emitted item.
- credit_return  in  1  downstream freed one slot, one credit per cycle high.
- credits  out  LOG_CREDITS+1  current credit count.
- sent_count  out  32  items emitted since reset; wraps modulo 2^32.
- credit_error  out  1  sticky; a credit was returned while credits == CREDITS.

## Operation
- Upstream protocol: when in_delete is 1 in a cycle, in_full and in_data already show the item *after* the one being deleted. When in_delete is 0, they show the current head. in_delete never depends combinationally on in_full, so there is no loop.
- Pop condition at each edge is `go = enable && in_full && (credits != 0)`.
- If go is true:
  - out_data <= in_data
  - out_strobe <= 1
  - in_delete <= 1
  - sent_count increments
  - credits decrements
- If go is false: out_strobe <= 0, in_delete <= 0, out_data holds.
- Item identity: the item captured at edge E is exactly the item deleted during the following cycle. Back-to-back pops are therefore legal and sustain 1 item/cycle.
- Credit update per edge:
  - go and credit_return together: unchanged.
  - go only: −1.
  - credit_return only: +1 when credits < CREDITS. When credits == CREDITS, set credit_error and leave credits unchanged.
  - The comparison uses the pre-edge value.
- credit_error clears only on reset.
- enable falling does not cancel a delete already registered, because that delete corresponds to an item already emitted.

## Timing
- Reset values:
  - in_delete = 0, out_strobe = 0, out_data = 0.
  - credits = CREDITS, sent_count = 0, credit_error = 0.
- Latency: in_full rising at cycle t (with credits and enable) gives out_strobe and in_delete both high in cycle t+1.
- Throughput: 1 item/cycle while in_full, enable and credits allow.
- Credits reaching 0: the pop at the edge that consumes the last credit still happens. Next pop waits for credit_return. The earliest restart is the edge after credit_return, i.e. a one-cycle bubble minimum.
- Upstream empty: in_full = 0 gives no pop. A stale in_data is never emitted.
- Reset mid-operation: the upstream buffer shares rst_n. Any registered delete or strobe is dropped in the reset cycle and outputs take their reset values on the next edge.
- credit_return in the reset cycle is ignored.

## Structure
- No shared package needed; all widths derive from the module parameters.
- Single flat module, no sub-module.
- The credit counter may optionally be factored as `credit_counter`, with parameters CREDITS/LOG_CREDITS and ports inc, dec, count, overflow.

## Test plan
- Basic drain:
  - Stimulus: upstream buffer pre-loaded with 0x11, 0x22, 0x33; enable = 1; CREDITS = 64.
  - Required: out_strobe on three consecutive cycles carrying 0x11, 0x22, 0x33; sent_count = 3; credits = 61; buffer empty.
- Credit exhaustion:
  - Stimulus: CREDITS = 4; 10 items queued; no credit_return.
  - Required: exactly 4 strobes, then idle with credits = 0.
  - Then pulse credit_return once. Required: exactly one more strobe, emitted on the cycle after the pulse.
- Simultaneous pop and return:
  - Stimulus: credits = 2; streaming items; credit_return held high for 5 cycles.
  - Required: credits stays 2 during overlap; 5 strobes with no gaps.
- Credit overflow:
  - Stimulus: after reset, pulse credit_return with no prior pops.
  - Required: credit_error = 1 and credits stays 64.
  - Then reset. Required: credit_error = 0.
- Enable and empty gaps:
  - Stimulus: toggle enable low for 3 cycles mid-stream; insert an empty gap upstream.
  - Required: no strobes while enable = 0 or in_full = 0; the order of 0xA0..0xA7 is preserved with none lost or duplicated.
- Reset mid-stream:
  - Stimulus: assert rst_n = 0 while in_delete = 1.
  - Required: next cycle in_delete = 0, out_strobe = 0, credits = CREDITS, sent_count = 0.

Source files
------------

// File: rtl/buffer_drain_pkg.sv
// Shared types for the buffer drain: credit counter operation decode.
package buffer_drain_pkg;

  typedef enum logic [1:0] {
    CR_HOLD,
    CR_DEC,
    CR_INC,
    CR_OVF
  } credit_op_e;

  // A pop and a return in the same cycle cancel out; a lone return at the
  // ceiling is an overflow rather than an increment.
  function automatic credit_op_e credit_op(input logic inc, input logic dec,
                                           input logic at_max);
    if (inc && !dec) return at_max ? CR_OVF : CR_INC;
    if (dec && !inc) return CR_DEC;
    return CR_HOLD;
  endfunction

endpackage

// File: rtl/buffer_drain_credit_counter.sv
// Credit counter: starts full, decrements per pop, increments per return,
// saturates at CREDITS and flags a return that would exceed it.
module credit_counter
  import buffer_drain_pkg::*;
#(
  parameter int CREDITS     = 64,
  parameter int LOG_CREDITS = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic                 dec,
  output logic [LOG_CREDITS:0] count,
  output logic                 overflow
);

  localparam logic [LOG_CREDITS:0] MAX = (LOG_CREDITS + 1)'(CREDITS);
  localparam logic [LOG_CREDITS:0] ONE = (LOG_CREDITS + 1)'(1);

  credit_op_e op;

  assign op       = credit_op(inc, dec, count == MAX);
  assign overflow = (op == CR_OVF);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= MAX;
    end else begin
      case (op)
        CR_DEC:  count <= count - ONE;
        CR_INC:  count <= count + ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/buffer_drain.sv
// Credit-limited drain: pops the upstream head through a delete strobe and
// re-emits it as a registered write strobe to the next stage.
module buffer_drain
  import buffer_drain_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int CREDITS     = 64,
  parameter int LOG_CREDITS = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 in_full,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 in_delete,
  output logic                 out_strobe,
  output logic [WIDTH-1:0]     out_data,
  input  logic                 credit_return,
  output logic [LOG_CREDITS:0] credits,
  output logic [31:0]          sent_count,
  output logic                 credit_error
);

  logic go;
  logic overflow;

  // in_full already reflects any delete in flight, so go needs no
  // correction for the item being popped this cycle.
  assign go = enable && in_full && (credits != '0);

  credit_counter #(
    .CREDITS    (CREDITS),
    .LOG_CREDITS(LOG_CREDITS)
  ) u_credit_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (credit_return),
    .dec     (go),
    .count   (credits),
    .overflow(overflow)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_delete    <= 1'b0;
      out_strobe   <= 1'b0;
      out_data     <= '0;
      sent_count   <= '0;
      credit_error <= 1'b0;
    end else begin
      in_delete  <= go;
      out_strobe <= go;
      if (go) begin
        out_data   <= in_data;
        sent_count <= sent_count + 32'd1;
      end
      if (overflow) credit_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_buffer_drain.sv
// Scoreboarded bench for buffer_drain with a delete-style upstream model.
module tb_buffer_drain;

  localparam int W  = 32;
  localparam int CR = 4;
  localparam int LC = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          in_full;
  logic [W-1:0]  in_data;
  logic          in_delete;
  logic          out_strobe;
  logic [W-1:0]  out_data;
  logic          credit_return;
  logic [LC:0]   credits;
  logic [31:0]   sent_count;
  logic          credit_error;

  buffer_drain #(.WIDTH(W), .CREDITS(CR), .LOG_CREDITS(LC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .in_full      (in_full),
    .in_data      (in_data),
    .in_delete    (in_delete),
    .out_strobe   (out_strobe),
    .out_data     (out_data),
    .credit_return(credit_return),
    .credits      (credits),
    .sent_count   (sent_count),
    .credit_error (credit_error)
  );

  always #5 clk = ~clk;

  // Upstream buffer: while a delete is in flight the port already shows the next item.
  logic [W-1:0] ubuf [0:1023];
  int rd = 0;
  int wr = 0;
  assign in_full = (rd + int'(in_delete)) < wr;
  assign in_data = ubuf[(rd + int'(in_delete)) & 1023];

  always @(posedge clk) begin
    if (!rst_n) rd <= 0;
    else if (in_delete) rd <= rd + 1;
  end

  // Reference model: items pending, credits as plain integers.
  int          m_cred = CR;
  int          m_sent = 0;
  int          m_emitted = 0;
  bit          m_err = 0;
  bit          m_strobe = 0;
  int          cyc = 0;

  always @(posedge clk) begin
    bit go;
    cyc = cyc + 1;
    if (!rst_n) begin
      m_cred = CR; m_sent = 0; m_emitted = 0; m_err = 0; m_strobe = 0;
    end else begin
      go = enable && (wr - m_emitted > 0) && (m_cred > 0);
      if (go && !credit_return) m_cred = m_cred - 1;
      else if (!go && credit_return) begin
        if (m_cred == CR) m_err = 1;
        else m_cred = m_cred + 1;
      end
      m_strobe = go;
      if (go) begin
        m_sent = m_sent + 1;
        m_emitted = m_emitted + 1;
      end
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard: expected data pushed at stimulus time, popped on each strobe.
  logic [W-1:0] exp_q[$];
  int strobe_cyc[$];
  int n_strobes = 0;
  bit mon_en = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_strobe", 64'(out_strobe), 64'(m_strobe));
      chk("in_delete", 64'(in_delete), 64'(m_strobe));
      chk("credits", 64'(credits), 64'(m_cred));
      chk("sent_count", 64'(sent_count), 64'(m_sent));
      chk("credit_error", 64'(credit_error), 64'(m_err));
      if (out_strobe === 1'b1) begin
        n_strobes++;
        strobe_cyc.push_back(cyc);
        if (exp_q.size() == 0) chk("unexpected_strobe", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("out_data", 64'(out_data), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic push(input logic [W-1:0] v);
    ubuf[wr & 1023] = v;
    exp_q.push_back(v);
    wr = wr + 1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    credit_return = 1'b0;
    @(posedge clk);
    #1;
    wr = 0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain_all(input string nm);
    int t = 0;
    enable = 1'b1;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      credit_return = (m_cred < CR);
      t++;
    end
    @(negedge clk);
    credit_return = 1'b0;
    cycles(2);
    chk(nm, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int s0, k;
    rst_n = 1'b0;
    enable = 1'b0;
    credit_return = 1'b0;
    cycles(2);
    mon_en = 1;
    rst_n = 1'b1;

    chk("reset_credits", 64'(credits), 64'(CR));
    chk("reset_sent", 64'(sent_count), 64'd0);
    chk("reset_out_data", 64'(out_data), 64'd0);
    chk("reset_strobe", 64'(out_strobe), 64'd0);

    // Basic drain
    enable = 1'b1;
    s0 = n_strobes;
    k = cyc;
    push(32'h11); push(32'h22); push(32'h33);
    cycles(6);
    chk("basic_strobes", 64'(n_strobes - s0), 64'd3);
    chk("basic_first_cyc", 64'(strobe_cyc[s0]), 64'(k + 1));
    chk("basic_last_cyc", 64'(strobe_cyc[s0 + 2]), 64'(k + 3));
    chk("basic_sent", 64'(sent_count), 64'd3);
    chk("basic_credits", 64'(credits), 64'(CR - 3));
    chk("basic_empty", 64'(in_full), 64'd0);

    // Credit exhaustion, then a single return
    do_reset();
    enable = 1'b1;
    s0 = n_strobes;
    for (int i = 0; i < 10; i++) push(32'h100 + 32'(i));
    cycles(10);
    chk("exhaust_strobes", 64'(n_strobes - s0), 64'(CR));
    chk("exhaust_credits", 64'(credits), 64'd0);
    k = cyc;
    credit_return = 1'b1;
    @(negedge clk);
    credit_return = 1'b0;
    cycles(5);
    chk("exhaust_one_more", 64'(n_strobes - s0), 64'(CR + 1));
    chk("exhaust_restart_cyc", 64'(strobe_cyc[strobe_cyc.size() - 1]), 64'(k + 2));
    chk("exhaust_idle_credits", 64'(credits), 64'd0);
    drain_all("exhaust_drained");

    // Simultaneous pop and return with two credits left
    do_reset();
    enable = 1'b1;
    push(32'h200); push(32'h201);
    cycles(4);
    chk("overlap_start_credits", 64'(credits), 64'd2);
    s0 = n_strobes;
    for (int i = 0; i < 8; i++) push(32'h300 + 32'(i));
    credit_return = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("overlap_credits", 64'(credits), 64'd2);
      chk("overlap_strobe", 64'(out_strobe), 64'd1);
    end
    credit_return = 1'b0;
    cycles(4);
    chk("overlap_total", 64'(n_strobes - s0), 64'd7);
    drain_all("overlap_drained");

    // Credit overflow
    do_reset();
    credit_return = 1'b1;
    @(negedge clk);
    credit_return = 1'b0;
    chk("ovf_error", 64'(credit_error), 64'd1);
    chk("ovf_credits", 64'(credits), 64'(CR));
    cycles(2);
    chk("ovf_sticky", 64'(credit_error), 64'd1);
    do_reset();
    chk("ovf_cleared", 64'(credit_error), 64'd0);

    // Enable and empty gaps, A0..A7 in order
    enable = 1'b1;
    s0 = n_strobes;
    push(32'hA0); push(32'hA1); push(32'hA2);
    @(negedge clk);
    enable = 1'b0;
    push(32'hA3); push(32'hA4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      credit_return = (m_cred < CR);
    end
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      credit_return = (m_cred < CR);
    end
    push(32'hA5); push(32'hA6); push(32'hA7);
    drain_all("gaps_drained");
    chk("gaps_strobes", 64'(n_strobes - s0), 64'd8);

    // Reset mid-stream
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 3; i++) push(32'h400 + 32'(i));
    k = 0;
    while (in_delete !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("midrst_delete_seen", 64'(in_delete), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    wr = 0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_delete", 64'(in_delete), 64'd0);
    chk("midrst_strobe", 64'(out_strobe), 64'd0);
    chk("midrst_credits", 64'(credits), 64'(CR));
    chk("midrst_sent", 64'(sent_count), 64'd0);
    rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      enable = ($urandom_range(0, 9) != 0);
      if (wr < 1000 && $urandom_range(0, 2) != 0) push($urandom);
      credit_return = (m_cred < CR) ? ($urandom_range(0, 2) != 0)
                                    : ($urandom_range(0, 99) == 0);
    end
    drain_all("random_drained");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
